// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot pixel scanner: Q4.12 coordinate
// format, iteration-count width and the scanner state encoding.
package mandel_pkg;

    localparam int COORD_W   = 16;
    localparam int FRAC_BITS = 12;
    localparam int ITER_W    = 8;

    // Count written for a pixel whose engine never answered (treated as inside the set).
    localparam logic [ITER_W-1:0] NOESCAPE_COUNT = 8'hFF;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } scan_state_e;

endpackage

// File: rtl/mandel_coord_gen.sv
// Raster coordinate generator: column/row counters plus incremental Q4.12
// accumulators for the real and imaginary parts. No multiplier; every
// addition wraps in 16-bit two's complement.
module mandel_coord_gen
    import mandel_pkg::*;
#(
    parameter int     COLS    = 640,
    parameter int     ROWS    = 480,
    parameter coord_t X_START = 16'hE000,
    parameter coord_t Y_START = 16'hF000,
    parameter coord_t STEP    = 16'h0013
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   load_i,
    input  logic   adv_i,
    output coord_t x_o,
    output coord_t y_o,
    output logic   last_o
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    coord_t           x_q, x_d;
    coord_t           y_q, y_d;

    // Next position: restart at the frame origin on load, otherwise step
    // along the row and wrap to the next row at its end.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        x_d   = x_q;
        y_d   = y_q;
        if (load_i) begin
            col_d = '0;
            row_d = '0;
            x_d   = X_START;
            y_d   = Y_START;
        end else if (adv_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                x_d   = X_START;
                row_d = row_q + ROW_W'(1);
                y_d   = y_q + STEP;
            end else begin
                col_d = col_q + COL_W'(1);
                x_d   = x_q + STEP;
            end
        end
    end

    // Position registers; cleared by reset so the request bus reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/mandel_scanner.sv
// Pixel-scan sequencer for the Mandelbrot iteration engine. Issues one
// coordinate per pixel in raster order over a valid/ready channel, waits
// for the iteration count and writes it to the frame buffer at row*COLS+col.
// Optional: define MANDEL_TIMEOUT_EN to bound the wait for an engine result
// (TIMEOUT cycles); a timed-out pixel is written as NOESCAPE_COUNT and the
// sticky timeout_flag output is raised.
module mandel_scanner
    import mandel_pkg::*;
#(
    parameter int     COLS    = 640,
    parameter int     ROWS    = 480,
    parameter int     ADDR_W  = 19,
    parameter coord_t X_START = 16'hE000,
    parameter coord_t Y_START = 16'hF000,
    parameter coord_t STEP    = 16'h0013
`ifdef MANDEL_TIMEOUT_EN
    ,
    parameter int     TIMEOUT = 1023
`endif
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [COORD_W-1:0] req_x,
    output logic [COORD_W-1:0] req_y,
    input  logic               res_valid,
    input  logic [ITER_W-1:0]  res_count,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [ITER_W-1:0]  wr_data
`ifdef MANDEL_TIMEOUT_EN
    ,
    output logic               timeout_flag
`endif
);

    scan_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ITER_W-1:0] count_q, count_d;
    logic              coord_load;
    logic              coord_adv;
    logic              coord_last;
    coord_t            cur_x;
    coord_t            cur_y;

`ifdef MANDEL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_flag_q, to_flag_d;
    logic            to_fire;

    // Final WAIT cycle reached with no result from the engine.
    assign to_fire = (state_q == WAIT) && !res_valid && (to_cnt_q == TO_LAST);
`endif

    mandel_coord_gen #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .X_START (X_START),
        .Y_START (Y_START),
        .STEP    (STEP)
    ) u_coord (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .load_i (coord_load),
        .adv_i  (coord_adv),
        .x_o    (cur_x),
        .y_o    (cur_y),
        .last_o (coord_last)
    );

    // Scanner sequencing: one request outstanding, one write per pixel.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        coord_load = 1'b0;
        coord_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    coord_load = 1'b1;
                    addr_d     = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    count_d = res_count;
                    state_d = WRITE;
                end
`ifdef MANDEL_TIMEOUT_EN
                else if (to_fire) begin
                    count_d = NOESCAPE_COUNT;
                    state_d = WRITE;
                end
`endif
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (coord_last) begin
                    state_d = DONE;
                end else begin
                    coord_adv = 1'b1;
                    state_d   = ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, write address and captured iteration count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

`ifdef MANDEL_TIMEOUT_EN
    // Wait-cycle counter restarts each WAIT visit; flag is sticky until the next accepted start.
    always_comb begin
        to_cnt_d  = (state_q == WAIT) ? to_cnt_q + TO_W'(1) : '0;
        to_flag_d = to_flag_q;
        if ((state_q == IDLE) && start) begin
            to_flag_d = 1'b0;
        end else if (to_fire) begin
            to_flag_d = 1'b1;
        end
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign timeout_flag = to_flag_q;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign req_valid = (state_q == ISSUE);
    assign wr_en     = (state_q == WRITE);
    assign req_x     = cur_x;
    assign req_y     = cur_y;
    assign wr_addr   = addr_q;
    assign wr_data   = count_q;

endmodule

// File: tb/tb_mandel_scanner.sv
// Scoreboard bench for mandel_scanner on a 4x3 grid with STEP 1.0/16.
// A behavioural engine model answers requests with randomized ready stalls
// and response delays; the expected coordinate and write streams are
// computed per frame and checked by an independent monitor.
module tb_mandel_scanner;

    localparam int          COLS   = 4;
    localparam int          ROWS   = 3;
    localparam int          NPIX   = COLS * ROWS;
    localparam int          ADDR_W = 4;
    localparam logic [15:0] XS     = 16'hE000;
    localparam logic [15:0] YS     = 16'hF000;
    localparam logic [15:0] ST     = 16'h0100;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              req_valid;
    logic              req_ready = 1'b0;
    logic [15:0]       req_x;
    logic [15:0]       req_y;
    logic              res_valid = 1'b0;
    logic [7:0]        res_count = 8'h00;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
`ifdef MANDEL_TIMEOUT_EN
    logic              timeout_flag;
`endif

    mandel_scanner #(
        .COLS    (COLS),
        .ROWS    (ROWS),
        .ADDR_W  (ADDR_W),
        .X_START (XS),
        .Y_START (YS),
        .STEP    (ST)
`ifdef MANDEL_TIMEOUT_EN
        ,
        .TIMEOUT (8)
`endif
    ) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .res_valid (res_valid),
        .res_count (res_count),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
`ifdef MANDEL_TIMEOUT_EN
        ,
        .timeout_flag (timeout_flag)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } rq_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    rq_t  rq_q[$];
    wr_t  wr_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_exp = 0;
    int   done_cnt = 0;
    int   wr_cnt = 0;
    int   frame_gen = 0;
    int   silent_pix = -1;
    int   spur_en = 0;
    logic [7:0] tbl [NPIX];
    int   rdy_tbl [NPIX];
    int   dly_tbl [NPIX];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pixel p sits at col p%COLS, row p/COLS.
    task automatic expect_frame();
        for (int p = 0; p < NPIX; p++) begin
            rq_t r;
            wr_t w;
            int  col;
            int  row;
            col    = p % COLS;
            row    = p / COLS;
            r.x    = 16'(int'(XS) + col * int'(ST));
            r.y    = 16'(int'(YS) + row * int'(ST));
            w.addr = ADDR_W'(p);
            w.data = (p == silent_pix) ? 8'hFF : tbl[p];
            rq_q.push_back(r);
            wr_q.push_back(w);
        end
        done_exp++;
    endtask

    task automatic randomize_tables();
        for (int p = 0; p < NPIX; p++) begin
            tbl[p]     = 8'($urandom_range(0, 255));
            rdy_tbl[p] = $urandom_range(0, 3);
            dly_tbl[p] = $urandom_range(1, 5);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [63:0] v;
        v = 64'({busy, done, req_valid, wr_en, wr_addr, wr_data, req_x, req_y});
`ifdef MANDEL_TIMEOUT_EN
        v = v | 64'(timeout_flag);
`endif
        chk(name, v, 64'h0);
    endtask

    // Runs one frame; mid_start pulses a stray start, abort_after >= 0 resets after that many writes.
    task automatic run_frame(input int mid_start, input int abort_after);
        int n;
        int d0;
        int w0;
        bit aborted;
        n       = 0;
        aborted = 0;
        frame_gen++;
        expect_frame();
        d0 = done_cnt;
        w0 = wr_cnt;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        while (done_cnt == d0 && n < 2000 && !aborted) begin
            @(negedge Clk);
            n++;
            start = (n == mid_start);
            if (abort_after >= 0 && (wr_cnt - w0) >= abort_after) begin
                Rst_n = 1'b0;
                #1;
                check_reset_outputs("reset_mid_frame");
                repeat (2) @(negedge Clk);
                check_reset_outputs("reset_held");
                rq_q.delete();
                wr_q.delete();
                done_exp = 0;
                Rst_n = 1'b1;
                repeat (3) @(negedge Clk);
                chk("no_done_on_abort", 64'(done_cnt - d0), 64'h0);
                aborted = 1;
            end
        end
        start = 1'b0;
        if (!aborted) begin
            chk("frame_done_count", 64'(done_cnt - d0), 64'h1);
            chk("frame_write_count", 64'(wr_cnt - w0), 64'(NPIX));
            if (done_cnt == d0) begin
                rq_q.delete();
                wr_q.delete();
                done_exp = 0;
            end
        end
    endtask

    // Behavioural engine: optional ready stall per request, response after a per-pixel delay.
    initial begin : engine
        int eng_gen;
        int hs_idx;
        int pend;
        int pend_idx;
        int rdy_cnt;
        eng_gen  = 0;
        hs_idx   = 0;
        pend     = -1;
        pend_idx = 0;
        rdy_cnt  = 0;
        forever begin
            @(negedge Clk);
            res_valid = 1'b0;
            if (!Rst_n || frame_gen != eng_gen) begin
                eng_gen   = frame_gen;
                hs_idx    = 0;
                pend      = -1;
                rdy_cnt   = 0;
                req_ready = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        res_valid = 1'b1;
                        res_count = tbl[pend_idx];
                        pend      = -1;
                    end
                end
                if (req_valid && hs_idx < NPIX) begin
                    if (rdy_cnt < rdy_tbl[hs_idx]) begin
                        req_ready = 1'b0;
                        rdy_cnt++;
                        if (spur_en != 0 && $urandom_range(0, 1) == 1) begin
                            res_valid = 1'b1;
                            res_count = 8'($urandom_range(0, 255));
                        end
                    end else begin
                        req_ready = 1'b1;
                        rdy_cnt   = 0;
                        pend_idx  = hs_idx;
                        pend      = (hs_idx == silent_pix) ? -1 : dly_tbl[hs_idx];
                        hs_idx++;
                    end
                end else begin
                    req_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake, write and done pulse.
    initial begin : monitor
        bit          hold;
        bit          prev_done;
        logic [15:0] hx;
        logic [15:0] hy;
        rq_t         er;
        wr_t         ew;
        hold      = 0;
        prev_done = 0;
        hx        = '0;
        hy        = '0;
        forever begin
            @(negedge Clk);
            #2;
            if (!Rst_n) begin
                hold      = 0;
                prev_done = 0;
            end else begin
                if (hold) begin
                    chk("req_stable", {req_valid, req_x, req_y}, {1'b1, hx, hy});
                end
                hold = req_valid && !req_ready;
                hx   = req_x;
                hy   = req_y;
                if (req_valid && req_ready) begin
                    if (rq_q.size() == 0) begin
                        chk("req_unexpected", 64'(rq_q.size()), 64'h1);
                    end else begin
                        er = rq_q.pop_front();
                        chk("req_x", 64'(req_x), 64'(er.x));
                        chk("req_y", 64'(req_y), 64'(er.y));
                    end
                end
                if (wr_en) begin
                    wr_cnt++;
                    if (wr_q.size() == 0) begin
                        chk("wr_unexpected", 64'(wr_q.size()), 64'h1);
                    end else begin
                        ew = wr_q.pop_front();
                        chk("wr_addr", 64'(wr_addr), 64'(ew.addr));
                        chk("wr_data", 64'(wr_data), 64'(ew.data));
                    end
                end
                if (prev_done) begin
                    chk("busy_after_done", 64'(busy), 64'h0);
                end
                if (done) begin
                    done_cnt++;
                    chk("done_expected", 64'(done_exp > 0), 64'h1);
                    chk("done_all_written", 64'(wr_q.size()), 64'h0);
                    chk("busy_at_done", 64'(busy), 64'h1);
                    if (done_exp > 0) done_exp--;
                end
                prev_done = done;
            end
        end
    end

    initial begin : main
        repeat (3) @(negedge Clk);
        check_reset_outputs("reset_initial");
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
        chk("idle_busy", 64'(busy), 64'h0);

        // Frame A: count = pixel+1 after 3 cycles, pixel 2 stalled 5 cycles,
        // stray start and stray results while in ISSUE.
        for (int p = 0; p < NPIX; p++) begin
            tbl[p]     = 8'(p + 1);
            rdy_tbl[p] = (p == 2) ? 5 : 0;
            dly_tbl[p] = 3;
        end
        spur_en    = 1;
        silent_pix = -1;
        run_frame(20, -1);

        // Frames B and C: randomized engine behaviour.
        for (int f = 0; f < 2; f++) begin
            randomize_tables();
            run_frame((f == 0) ? 9 : -1, -1);
        end

        // Frame D aborted by reset after 6 writes, then a clean restart.
        randomize_tables();
        run_frame(-1, 6);
        randomize_tables();
        run_frame(-1, -1);

`ifdef MANDEL_TIMEOUT_EN
        chk("flag_clear_before", 64'(timeout_flag), 64'h0);
        randomize_tables();
        silent_pix = 5;
        run_frame(-1, -1);
        chk("flag_set", 64'(timeout_flag), 64'h1);
        repeat (4) @(negedge Clk);
        chk("flag_sticky", 64'(timeout_flag), 64'h1);
        silent_pix = -1;
        randomize_tables();
        run_frame(-1, -1);
        chk("flag_cleared_by_start", 64'(timeout_flag), 64'h0);
`endif

        repeat (3) @(negedge Clk);
        chk("sb_req_empty", 64'(rq_q.size()), 64'h0);
        chk("sb_wr_empty", 64'(wr_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
